// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake and decoded-field bundle for decode_stage.
// master = fetch/execute side, slave = decode_stage.
interface decode_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              if_valid;
  logic              if_ready;
  logic [WIDTH-1:0]  if_instr;
  logic [WIDTH-1:0]  if_pc;
  logic              ex_ready;
  logic [REG_AW-1:0] rf_read_addr1;
  logic [REG_AW-1:0] rf_read_addr2;
  logic              id_valid;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [WIDTH-1:0]  id_imm;
  logic [WIDTH-1:0]  id_pc;
  logic [6:0]        id_opcode;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  if_ready, rf_read_addr1, rf_read_addr2, id_valid, id_rd, id_rs1, id_rs2,
           id_imm, id_pc, id_opcode, id_funct3, id_funct7,
           id_reg_write, id_mem_read, id_mem_write, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output if_ready, rf_read_addr1, rf_read_addr2, id_valid, id_rd, id_rs1, id_rs2,
           id_imm, id_pc, id_opcode, id_funct3, id_funct7,
           id_reg_write, id_mem_read, id_mem_write, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage with load-use stall, flush and ex backpressure.
// Optional macro DECODE_ILLEGAL_TRAP_EN flags non-RV32I opcodes as illegal.
module decode_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  decode_stage_if.slave d
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [31:0]       ins;
  logic [6:0]        op;
  logic [REG_AW-1:0] rd_in, rs1_in, rs2_in;
  logic [31:0]       imm32;
  logic              rw_d, mr_d, mw_d, ill_d, use1, use2;
  logic              load_use, ready, accept;

  logic              valid_q, rw_q, mr_q, mw_q, ill_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0]  imm_q, pc_q;
  logic [6:0]        op_q, f7_q;
  logic [2:0]        f3_q;

  assign ins    = d.if_instr[31:0];
  assign op     = ins[6:0];
  assign rd_in  = REG_AW'(ins[11:7]);
  assign rs1_in = REG_AW'(ins[19:15]);
  assign rs2_in = REG_AW'(ins[24:20]);

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_comb begin
    ill_d = 1'b0;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYS: ill_d = 1'b0;
      default: ill_d = 1'b1;
    endcase
  end
`else
  assign ill_d = 1'b0;
`endif

  always_comb begin
    imm32 = '0;
    rw_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    case (op)
      OP_R:    begin rw_d = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      OP_IMM, OP_JALR: begin
        imm32 = {{20{ins[31]}}, ins[31:20]};
        rw_d  = 1'b1; use1 = 1'b1;
      end
      OP_LOAD: begin
        imm32 = {{20{ins[31]}}, ins[31:20]};
        rw_d  = 1'b1; mr_d = 1'b1; use1 = 1'b1;
      end
      OP_STORE: begin
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        mw_d  = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OP_BR: begin
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        use1  = 1'b1; use2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {ins[31:12], 12'b0};
        rw_d  = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        rw_d  = 1'b1;
      end
      default: ;
    endcase
    if (rd_in == '0) rw_d = 1'b0;
    // an illegal instruction must not touch architectural state
    if (ill_d) begin
      rw_d = 1'b0;
      mr_d = 1'b0;
      mw_d = 1'b0;
    end
  end

  assign load_use = valid_q && mr_q && (rd_q != '0) && d.if_valid &&
                    ((use1 && rd_q == rs1_in) || (use2 && rd_q == rs2_in));
  assign ready    = reset && (!valid_q || d.ex_ready) && !load_use && !flush;
  assign accept   = d.if_valid && ready;

  // sync-read register file: address follows whatever id_* will hold next cycle
  assign d.rf_read_addr1 = accept ? rs1_in : rs1_q;
  assign d.rf_read_addr2 = accept ? rs2_in : rs2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rd_q    <= rd_in;
      rs1_q   <= rs1_in;
      rs2_q   <= rs2_in;
      imm_q   <= WIDTH'($signed(imm32));
      pc_q    <= d.if_pc;
      op_q    <= op;
      f3_q    <= ins[14:12];
      f7_q    <= ins[31:25];
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      ill_q   <= ill_d;
    end else if (d.ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign d.if_ready     = ready;
  assign d.id_valid     = valid_q;
  assign d.id_rd        = rd_q;
  assign d.id_rs1       = rs1_q;
  assign d.id_rs2       = rs2_q;
  assign d.id_imm       = imm_q;
  assign d.id_pc        = pc_q;
  assign d.id_opcode    = op_q;
  assign d.id_funct3    = f3_q;
  assign d.id_funct7    = f7_q;
  assign d.id_reg_write = valid_q & rw_q;
  assign d.id_mem_read  = valid_q & mr_q;
  assign d.id_mem_write = valid_q & mw_q;
  assign d.id_illegal   = ill_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and PC width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have port if_valid  input  1  fetch presents instruction.
REQ-006 SHALL have port if_ready  output  1  stage accepts instruction this cycle.
REQ-007 SHALL have port if_instr  input  WIDTH  RV32I instruction word.
REQ-008 SHALL have port if_pc  input  WIDTH  PC of if_instr.
REQ-009 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-010 SHALL have port ex_ready  input  1  execute stage consumes id outputs.
REQ-011 SHALL have ports rf_read_addr1, rf_read_addr2  output  REG_AW  register-file read addresses.
REQ-012 SHALL have port id_valid  output  1  id_* fields hold a valid decoded instruction.
REQ-013 SHALL have ports id_rd, id_rs1, id_rs2  output  REG_AW  decoded register indices.
REQ-014 SHALL have ports id_imm, id_pc  output  WIDTH  sign-extended immediate, instruction PC.
REQ-015 SHALL have ports id_opcode 7, id_funct3 3, id_funct7 7  output  decoded fields.
REQ-016 SHALL have ports id_reg_write, id_mem_read, id_mem_write, id_illegal  output  1  control flags.

Function
REQ-017 SHALL accept an instruction when if_valid and if_ready are both 1 at a rising edge; id_* update on that edge (1-cycle latency).
REQ-018 SHALL drive if_ready = (!id_valid or ex_ready) and !load_use and !flush.
REQ-019 SHALL drive rf_read_addr1/2 combinationally from if_instr[19:15]/[24:20] when accepting, else from held id_rs1/id_rs2, so synchronous register-file read data aligns with id_* every cycle.
REQ-020 SHALL hold all id_* stable while id_valid=1 and ex_ready=0.
REQ-021 SHALL clear id_valid on an edge where ex_ready=1 and no instruction is accepted.
REQ-022 SHALL assert load_use when id_valid=1, id_mem_read=1, id_rd!=0, and id_rd equals incoming rs1 (opcodes using rs1) or rs2 (R, S, B types); one bubble (id_valid=0) results, then the instruction is accepted.
REQ-023 SHALL on flush=1 set id_valid=0 at the next edge and accept nothing that cycle; flush has priority over all other events.
REQ-024 SHALL generate immediates: I (0010011, 0000011, 1100111), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits 0), J (1101111, bit0=0); R-type and others give 0; all sign-extended from instr[31].
REQ-025 SHALL set id_reg_write=1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC, and force 0 when rd=0.
REQ-026 SHALL set id_mem_read=1 only for 0000011 and id_mem_write=1 only for 0100011.
REQ-027 SHALL force id_reg_write, id_mem_read, id_mem_write to 0 whenever id_valid=0.

Reset
REQ-028 SHALL on reset=0 set id_valid, id_rd, id_rs1, id_rs2, id_imm, id_pc, id_opcode, id_funct3, id_funct7, id_illegal and all control flags to 0.
REQ-029 SHALL hold if_ready=0 while reset=0; a reset arriving mid-stall or mid-hold discards the instruction.

Configuration
REQ-030 SHALL support macro DECODE_ILLEGAL_TRAP_EN.
REQ-031 With DECODE_ILLEGAL_TRAP_EN defined, SHALL set id_illegal=1 for any opcode outside the RV32I base set or instr[1:0]!=11, and force reg_write/mem_read/mem_write to 0 for it.
REQ-032 Without DECODE_ILLEGAL_TRAP_EN, id_illegal SHALL be constant 0 and unknown opcodes decode as no-op controls.

Verification
REQ-033 Reset: reset=0 for 2 cycles with if_valid=1 -> if_ready=0, id_valid=0, id_imm=0; release -> first instruction accepted next edge.
REQ-034 Immediate: accept 0xFFF00093 (addi x1,x0,-1) -> id_imm=0xFFFFFFFF, id_rd=1, id_reg_write=1 one cycle later.
REQ-035 Load-use: lw x5,0(x2) then add x6,x5,x1 -> if_ready=0 one cycle, one bubble, add accepted next cycle; rf_read_addr1=5 at acceptance.
REQ-036 Backpressure: ex_ready=0 for 3 cycles with id_valid=1 -> id_* and rf_read_addr1/2 unchanged, if_ready=0.
REQ-037 Flush: flush=1 with if_valid=1 and id_valid=1 -> id_valid=0 next edge, incoming instruction not accepted.
REQ-038 Illegal (DECODE_ILLEGAL_TRAP_EN): accept 0x0000007F -> id_illegal=1, id_reg_write=0; without macro id_illegal=0.
